consumer: RTL and testbench

//  Read-side agent of the async FIFO; mirrors the write-side producer.

---
 rtl/consumer.sv | 93 +++++++++
 tb/tb_consumer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/consumer.sv
// consumer: read-domain agent of the async FIFO. Pops words into a small circular
// prefetch buffer and presents them downstream on a valid/ready stream.
module consumer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  rd_req,
  input  logic                  f_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [OCC_W-1:0]        count, count_nxt;
  logic                    inflight;
  logic                    hs, land, pending, room;
  logic                    r_en_nxt;
  logic [DATA_WIDTH-1:0]   head, d_out_nxt;

  // Next-state, pointer and output computation
  always_comb begin
    state_nxt  = state;
    hs         = d_valid & d_ready;
    land       = inflight;
    count_nxt  = count + OCC_W'(land) - OCC_W'(hs);
    wr_ptr_nxt = wr_ptr + PTR_W'(land);
    rd_ptr_nxt = rd_ptr + PTR_W'(hs);
    pending    = (count != '0) | inflight | r_en;
    room       = (SUM_W'(count) + SUM_W'(inflight) + SUM_W'(r_en)) < SUM_W'(BUF_DEPTH);
    r_en_nxt   = rd_req & ~f_empty & room;
    // A word landing into a buffer that empties this cycle becomes the head directly
    head       = (land && (count == OCC_W'(hs))) ? fifo_rdata : buf_mem[rd_ptr_nxt];
    d_out_nxt  = (count_nxt != '0) ? head : '0;

    case (state)
      IDLE:    if (rd_req) state_nxt = ACTIVE;
      ACTIVE:  if (!rd_req) state_nxt = pending ? DRAIN : IDLE;
      DRAIN: begin
        if (rd_req)        state_nxt = ACTIVE;
        else if (!pending) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      r_en     <= 1'b0;
      d_valid  <= 1'b0;
      d_out    <= '0;
      busy     <= 1'b0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      inflight <= r_en;
      r_en     <= r_en_nxt;
      d_valid  <= (count_nxt != '0);
      d_out    <= d_out_nxt;
      busy     <= (state_nxt != IDLE);
      word_cnt <= word_cnt + CNT_WIDTH'(hs);
    end
  end

  // Buffer storage needs no reset; entries are only read while counted valid
  always_ff @(posedge r_clk) begin
    if (inflight) buf_mem[wr_ptr] <= fifo_rdata;
  end

endmodule

// File: tb/tb_consumer.sv
// tb_consumer: directed vector tables plus hand-written sequences against a
// small behavioural FIFO model feeding the consumer read port.
module tb_consumer;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          r_clk = 1'b0;
  logic          rrst;
  logic          rd_req;
  logic          f_empty;
  logic [DW-1:0] fifo_rdata = '0;
  logic          r_en;
  logic [DW-1:0] d_out;
  logic          d_valid;
  logic          d_ready;
  logic          busy;
  logic [CW-1:0] word_cnt;

  always #5 r_clk = ~r_clk;

  consumer #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .r_clk(r_clk), .rrst(rrst), .rd_req(rd_req), .f_empty(f_empty),
    .fifo_rdata(fifo_rdata), .r_en(r_en), .d_out(d_out), .d_valid(d_valid),
    .d_ready(d_ready), .busy(busy), .word_cnt(word_cnt)
  );

  // FIFO model: empty also accounts for a pop already requested this cycle
  logic [DW-1:0] mem [0:63];
  int unsigned   wptr = 0;
  int unsigned   rptr = 0;

  always @(posedge r_clk) begin
    if (r_en) begin
      fifo_rdata <= mem[rptr[5:0]];
      rptr       <= rptr + 1;
    end
  end

  assign f_empty = ((wptr - rptr) <= (r_en ? 32'd1 : 32'd0));

  typedef struct {
    logic          rd_req;
    logic          d_ready;
    logic          exp_r_en;
    logic          exp_d_valid;
    logic [DW-1:0] exp_d_out;
    logic [CW-1:0] exp_cnt;
    logic          exp_busy;
  } vec_t;

  vec_t vec [40];
  int   nvec   = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rq, input logic rdy, input logic ren, input logic dv,
                     input logic [31:0] dout, input int cnt, input logic bz);
    vec[nvec].rd_req      = rq;
    vec[nvec].d_ready     = rdy;
    vec[nvec].exp_r_en    = ren;
    vec[nvec].exp_d_valid = dv;
    vec[nvec].exp_d_out   = dout;
    vec[nvec].exp_cnt     = CW'(cnt);
    vec[nvec].exp_busy    = bz;
    nvec++;
  endtask

  task automatic step();
    @(posedge r_clk);
    @(negedge r_clk);
  endtask

  task automatic push(input logic [31:0] w);
    mem[wptr[5:0]] = w;
    wptr++;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    step();
    step();
    rrst = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      rd_req  = vec[i].rd_req;
      d_ready = vec[i].d_ready;
      step();
      check($sformatf("%s[%0d] r_en", tag, i - lo), 32'(r_en), 32'(vec[i].exp_r_en));
      check($sformatf("%s[%0d] d_valid", tag, i - lo), 32'(d_valid), 32'(vec[i].exp_d_valid));
      check($sformatf("%s[%0d] d_out", tag, i - lo), d_out, vec[i].exp_d_out);
      check($sformatf("%s[%0d] word_cnt", tag, i - lo), 32'(word_cnt), 32'(vec[i].exp_cnt));
      check($sformatf("%s[%0d] busy", tag, i - lo), 32'(busy), 32'(vec[i].exp_busy));
    end
  endtask

  initial begin
    rrst    = 1'b1;
    rd_req  = 1'b0;
    d_ready = 1'b0;

    // Streaming: 8 words, d_ready=1 (rows 0..11, one row per clock after reset release)
    add(1,1, 1,0, 32'h00,0, 1);
    add(1,1, 1,0, 32'h00,0, 1);
    add(1,1, 1,1, 32'h10,0, 1);
    add(1,1, 1,1, 32'h11,1, 1);
    add(1,1, 1,1, 32'h12,2, 1);
    add(1,1, 1,1, 32'h13,3, 1);
    add(1,1, 1,1, 32'h14,4, 1);
    add(1,1, 1,1, 32'h15,5, 1);
    add(1,1, 0,1, 32'h16,6, 1);
    add(1,1, 0,1, 32'h17,7, 1);
    add(1,1, 0,0, 32'h00,8, 1);
    add(1,1, 0,0, 32'h00,8, 1);
    // Backpressure: 10 words, d_ready=0 for 7 clocks then 1 (rows 12..28)
    add(1,0, 1,0, 32'h00,0, 1);
    add(1,0, 1,0, 32'h00,0, 1);
    add(1,0, 1,1, 32'h20,0, 1);
    add(1,0, 1,1, 32'h20,0, 1);
    add(1,0, 0,1, 32'h20,0, 1);
    add(1,0, 0,1, 32'h20,0, 1);
    add(1,0, 0,1, 32'h20,0, 1);
    add(1,1, 0,1, 32'h21,1, 1);
    add(1,1, 1,1, 32'h22,2, 1);
    add(1,1, 1,1, 32'h23,3, 1);
    add(1,1, 1,1, 32'h24,4, 1);
    add(1,1, 1,1, 32'h25,5, 1);
    add(1,1, 1,1, 32'h26,6, 1);
    add(1,1, 1,1, 32'h27,7, 1);
    add(1,1, 0,1, 32'h28,8, 1);
    add(1,1, 0,1, 32'h29,9, 1);
    add(1,1, 0,0, 32'h00,10, 1);

    // Reset held with fetch requested and FIFO non-empty
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    @(negedge r_clk);
    rd_req  = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset r_en", 32'(r_en), 32'd0);
      check("reset d_valid", 32'(d_valid), 32'd0);
      check("reset word_cnt", 32'(word_cnt), 32'd0);
    end
    check("reset busy", 32'(busy), 32'd0);
    check("reset d_out", d_out, 32'd0);
    rrst = 1'b0;
    run_rows(0, 11, "stream");

    do_reset();
    for (int i = 0; i < 10; i++) push(32'h20 + 32'(i));
    run_rows(12, 28, "bp");

    // Empty FIFO: fetch enabled but nothing to pop
    do_reset();
    rd_req  = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("empty[%0d] r_en", i), 32'(r_en), 32'd0);
      check($sformatf("empty[%0d] d_valid", i), 32'(d_valid), 32'd0);
      check($sformatf("empty[%0d] busy", i), 32'(busy), 32'd1);
    end

    // Drain: 2 buffered + 1 in flight when rd_req drops; new FIFO words must not be popped
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h30 + 32'(i));
    rd_req  = 1'b1;
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("drain pre r_en", 32'(r_en), 32'd0);
    check("drain pre d_out", d_out, 32'h30);
    rd_req = 1'b0;
    push(32'h33);
    push(32'h34);
    step();
    check("drain e5 r_en", 32'(r_en), 32'd0);
    check("drain e5 busy", 32'(busy), 32'd1);
    step();
    check("drain e6 d_out", d_out, 32'h30);
    d_ready = 1'b1;
    step();
    check("drain e7 d_out", d_out, 32'h31);
    step();
    check("drain e8 d_out", d_out, 32'h32);
    check("drain e8 r_en", 32'(r_en), 32'd0);
    step();
    check("drain e9 d_valid", 32'(d_valid), 32'd0);
    check("drain e9 word_cnt", 32'(word_cnt), 32'd3);
    check("drain e9 busy", 32'(busy), 32'd1);
    step();
    check("drain e10 busy", 32'(busy), 32'd0);
    check("drain e10 r_en", 32'(r_en), 32'd0);
    check("drain e10 word_cnt", 32'(word_cnt), 32'd3);

    // Reset mid-run with 3 words buffered and 1 in flight
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
    rd_req  = 1'b1;
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midrst pre d_out", d_out, 32'h33);
    check("midrst pre d_valid", 32'(d_valid), 32'd1);
    rrst = 1'b1;
    #1;
    check("midrst r_en", 32'(r_en), 32'd0);
    check("midrst d_valid", 32'(d_valid), 32'd0);
    check("midrst d_out", d_out, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst word_cnt", 32'(word_cnt), 32'd0);
    @(negedge r_clk);
    rrst    = 1'b0;
    d_ready = 1'b1;
    step();
    check("resume e1 r_en", 32'(r_en), 32'd1);
    check("resume e1 d_valid", 32'(d_valid), 32'd0);
    step();
    step();
    check("resume e3 d_out", d_out, 32'h42);
    check("resume e3 word_cnt", 32'(word_cnt), 32'd0);
    step();
    check("resume e4 d_out", d_out, 32'h43);
    check("resume e4 word_cnt", 32'(word_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
